// File: rtl/fetch_stage_if.sv
// IF-stage bundle: instruction-memory request/response plus the IF/ID entry and decoded fields.
// master = fetch stage, slave = memory/decode side (testbench).
interface fetch_stage_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;

  modport master (
    output imem_read, imem_address,
    input  imem_rdata, imem_resp,
    input  id_ready, redirect, redirect_pc,
    output if_valid, if_pc, if_instr,
    output opcode, funct3, funct7, rs1, rs2, rd
  );

  modport slave (
    input  imem_read, imem_address,
    output imem_rdata, imem_resp,
    output id_ready, redirect, redirect_pc,
    input  if_valid, if_pc, if_instr,
    input  opcode, funct3, funct7, rs1, rs2, rd
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch + IF/ID register; response at edge N is visible in cycle N+1 (fields are combinational).
// id_ready low parks one extra response in a skid entry and stops requesting; FETCH_PERF_EN adds perf counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h40000060
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_squashed
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  entry_t      out_q, out_d;
  entry_t      skid_q, skid_d;
  logic        imem_read_q, imem_read_d;

  logic [31:0] pc_inc;
  logic [31:0] redirect_pc_al;

  assign pc_inc         = pc_q + 32'd4;
  assign redirect_pc_al = {bus.redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    out_d      = out_q;
    skid_d     = skid_q;

    unique case (state_q)
      FETCH: begin
        if (bus.imem_resp) begin
          if (!out_q.vld || bus.id_ready) begin
            out_d = {1'b1, req_addr_q, bus.imem_rdata};
          end else begin
            skid_d  = {1'b1, req_addr_q, bus.imem_rdata};
            state_d = HOLD;
          end
          pc_d       = pc_inc;
          req_addr_d = pc_inc;
        end else if (bus.id_ready) begin
          out_d.vld = 1'b0;
        end
      end
      HOLD: begin
        if (bus.id_ready) begin
          out_d      = skid_q;
          skid_d.vld = 1'b0;
          state_d    = FETCH;
        end
      end
      DROP: begin
        if (bus.imem_resp) begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // A request still in flight must be drained before the new path is requested.
    if (bus.redirect) begin
      pc_d       = redirect_pc_al;
      out_d.vld  = 1'b0;
      skid_d.vld = 1'b0;
      if (state_q != HOLD && !bus.imem_resp) begin
        state_d    = DROP;
        req_addr_d = req_addr_q;
      end else begin
        req_addr_d = redirect_pc_al;
        state_d    = FETCH;
      end
    end

    imem_read_d = (state_d != HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      out_q       <= '0;
      skid_q      <= '0;
      imem_read_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      imem_read_q <= imem_read_d;
    end
  end

  assign bus.imem_read    = imem_read_q;
  assign bus.imem_address = req_addr_q;
  assign bus.if_valid     = out_q.vld;
  assign bus.if_pc        = out_q.pc;
  assign bus.if_instr     = out_q.instr;
  assign bus.opcode       = out_q.vld ? out_q.instr[6:0] : 7'h00;
  assign bus.funct3       = out_q.instr[14:12];
  assign bus.funct7       = out_q.instr[31:25];
  assign bus.rs1          = out_q.instr[19:15];
  assign bus.rs2          = out_q.instr[24:20];
  assign bus.rd           = out_q.instr[11:7];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_squashed_q, perf_squashed_d;
  logic [1:0]  squash_inc;
  logic [32:0] fetched_sum, squashed_sum;

  always_comb begin
    squash_inc      = 2'd0;
    fetched_sum     = {1'b0, perf_fetched_q};
    squashed_sum    = {1'b0, perf_squashed_q};
    perf_fetched_d  = perf_fetched_q;
    perf_squashed_d = perf_squashed_q;
    if (bus.redirect) begin
      squash_inc = {1'b0, out_q.vld} + {1'b0, skid_q.vld}
                 + {1'b0, bus.imem_resp && state_q != HOLD};
      squashed_sum    = {1'b0, perf_squashed_q} + {31'd0, squash_inc};
      perf_squashed_d = squashed_sum[32] ? 32'hFFFF_FFFF : squashed_sum[31:0];
    end else if (state_q == FETCH && bus.imem_resp) begin
      fetched_sum    = {1'b0, perf_fetched_q} + 33'd1;
      perf_fetched_d = fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched_q  <= '0;
      perf_squashed_q <= '0;
    end else begin
      perf_fetched_q  <= perf_fetched_d;
      perf_squashed_q <= perf_squashed_d;
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then randomized traffic vs a queue model.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h40000060;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus ();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_squashed (perf_squashed)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model: the IF/ID stage seen as a FIFO of at most two entries (out + skid).
  logic [31:0] mq_pc[$];
  logic [31:0] mq_ins[$];
  logic        model_known = 1'b0;
  logic        stale = 1'b0;
  logic [31:0] stale_addr = '0;
  logic [31:0] next_pc = '0;
  longint      m_fetched = 0;
  longint      m_squashed = 0;

  // Memory: responds after mem_lat cycles of a held request.
  int  mem_cnt = 0;
  int  mem_lat = 0;
  bit  rand_lat = 1'b0;
  bit  const_data = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return const_data ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234);
  endfunction

  function automatic logic m_read();
    return mq_pc.size() < 2;
  endfunction

  function automatic logic [31:0] m_addr();
    return stale ? stale_addr : next_pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    if (model_known) begin
      chk("imem_read", {31'd0, bus.imem_read}, {31'd0, m_read()});
      chk("imem_address", bus.imem_address, m_addr());
      chk("if_valid", {31'd0, bus.if_valid}, {31'd0, mq_pc.size() > 0});
      if (mq_pc.size() > 0) begin
        chk("if_pc", bus.if_pc, mq_pc[0]);
        chk("if_instr", bus.if_instr, mq_ins[0]);
        chk("fields", {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode}, mq_ins[0]);
      end else begin
        chk("opcode_idle", {25'd0, bus.opcode}, 32'd0);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched[31:0]);
      chk("perf_squashed", perf_squashed, m_squashed[31:0]);
`endif
    end
  endtask

  task automatic model_update(input logic r, input logic idr, input logic red,
                              input logic [31:0] rp, input logic resp, input logic [31:0] rdat);
    if (!r) begin
      mq_pc.delete(); mq_ins.delete();
      stale = 1'b0; next_pc = RST_PC;
      m_fetched = 0; m_squashed = 0;
      model_known = 1'b1;
    end else if (model_known) begin
      if (red) begin
        m_squashed += mq_pc.size() + (resp ? 1 : 0);
        if (m_squashed > 64'hFFFF_FFFF) m_squashed = 64'hFFFF_FFFF;
        if (!resp && m_read()) begin
          stale_addr = m_addr();
          stale = 1'b1;
        end else begin
          stale = 1'b0;
        end
        mq_pc.delete(); mq_ins.delete();
        next_pc = rp & 32'hFFFF_FFFC;
      end else begin
        if (idr && mq_pc.size() > 0) begin
          void'(mq_pc.pop_front());
          void'(mq_ins.pop_front());
        end
        if (resp) begin
          if (stale) begin
            stale = 1'b0;
          end else begin
            mq_pc.push_back(next_pc);
            mq_ins.push_back(rdat);
            next_pc = next_pc + 32'd4;
            if (m_fetched < 64'hFFFF_FFFF) m_fetched++;
          end
        end
      end
    end
  endtask

  // One clock: compare at negedge, drive inputs + memory, update model at posedge.
  task automatic step(input logic r, input logic idr, input logic red, input logic [31:0] rp);
    logic        resp;
    logic        rd_before;
    logic [31:0] rdat;
    @(negedge clk);
    check_model();
    rd_before = model_known && m_read();
    resp = rd_before && (mem_cnt >= mem_lat);
    rdat = resp ? mem_word(m_addr()) : $urandom;
    rst = r;
    bus.id_ready = idr;
    bus.redirect = red;
    bus.redirect_pc = rp;
    bus.imem_resp = resp;
    bus.imem_rdata = rdat;
    @(posedge clk);
    model_update(r, idr, red, rp, resp, rdat);
    if (!r) mem_cnt = 0;
    else if (resp) begin
      mem_cnt = 0;
      if (rand_lat) mem_lat = $urandom_range(3, 0);
    end else if (rd_before) mem_cnt++;
    #1;
  endtask

  initial begin
    bus.id_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_resp = 1'b0;
    bus.imem_rdata = '0;

    // Reset state
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("rst_read", {31'd0, bus.imem_read}, 32'd1);
    chk("rst_addr", bus.imem_address, 32'h40000060);
    chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_f", perf_fetched, 32'd0);
    chk("rst_perf_s", perf_squashed, 32'd0);
`endif

    // Sequential fetch, single-cycle memory
    mem_lat = 0;
    step(1, 1, 0, 0);
    chk("seq_pc0", bus.if_pc, 32'h40000060);
    chk("seq_op", {25'd0, bus.opcode}, 32'h13);
    chk("seq_addr1", bus.imem_address, 32'h40000064);
    step(1, 1, 0, 0);
    chk("seq_pc1", bus.if_pc, 32'h40000064);
    chk("seq_addr2", bus.imem_address, 32'h40000068);

    // Stall into HOLD, then release
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("hold_read", {31'd0, bus.imem_read}, 32'd0);
    chk("hold_pc", bus.if_pc, 32'h40000060);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("hold_pc_kept", bus.if_pc, 32'h40000060);
    step(1, 1, 0, 0);
    chk("rel_pc", bus.if_pc, 32'h40000064);
    chk("rel_addr", bus.imem_address, 32'h40000068);
    chk("rel_read", {31'd0, bus.imem_read}, 32'd1);

    // Redirect with slow outstanding request -> DROP
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    mem_lat = 3;
    step(1, 1, 1, 32'h40000100);
    chk("drop_addr0", bus.imem_address, 32'h40000064);
    chk("drop_valid", {31'd0, bus.if_valid}, 32'd0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("drop_addr2", bus.imem_address, 32'h40000064);
    step(1, 1, 0, 0);
    chk("drop_new", bus.imem_address, 32'h40000100);
    chk("drop_nodata", {31'd0, bus.if_valid}, 32'd0);

    // Redirect coincident with response while stalled
    mem_lat = 0;
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 32'h40000203);
    chk("coin_addr", bus.imem_address, 32'h40000200);
    chk("coin_valid", {31'd0, bus.if_valid}, 32'd0);

    // Reset while in HOLD and while in DROP
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rsthold_addr", bus.imem_address, 32'h40000060);
    chk("rsthold_read", {31'd0, bus.imem_read}, 32'd1);
    step(1, 1, 0, 0);
    mem_lat = 3;
    step(1, 1, 1, 32'h40000400);
    step(0, 1, 0, 0);
    chk("rstdrop_addr", bus.imem_address, 32'h40000060);
    chk("rstdrop_valid", {31'd0, bus.if_valid}, 32'd0);
    mem_lat = 0;
    mem_cnt = 0;

`ifdef FETCH_PERF_EN
    step(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("perf_f10", perf_fetched, 32'd10);
    step(1, 0, 1, 32'h40000800);
    chk("perf_s2", perf_squashed, 32'd2);
    step(0, 1, 0, 0);
    chk("perf_f_rst", perf_fetched, 32'd0);
    chk("perf_s_rst", perf_squashed, 32'd0);
`endif

    // Randomized traffic
    const_data = 1'b0;
    rand_lat = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(199, 0) != 0),
           ($urandom_range(99, 0) < 70),
           ($urandom_range(99, 0) < 8),
           $urandom);
    end
    step(1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
